calc_op_sequencer: RTL and testbench

- Schedules all arithmetic for the keypad calculator on signed Q1.9.6 operands (16 bit: 1 sign, 9 integer, 6 fraction).
- Sits between the calculator FSM and a shared arithmetic datapath, and uses a valid/ready handshake on both sides.
- ADD, SUB and MUL complete in a fixed short latency. DIV runs an iterative restoring divider over multiple cycles.
- Replaces the combinational `/` and fixes sign, saturation and divide-by-zero behaviour.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_div_iter.sv | 69 ++++++
 rtl/calc_op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared op codes, Q1.9.6 format constants, FSM states and the response record
// for the calculator arithmetic sequencer.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 6;

  localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [Q_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [Q_W-1:0] result;
    logic           ovf;
    logic           dz;
    logic           badop;
  } rsp_t;

endpackage

// File: rtl/calc_div_iter.sv
// Restoring divider, one quotient bit per cycle; unsigned magnitudes only.
// o_done/o_quotient describe the step being taken this cycle, so the caller
// can latch the final quotient on the same edge the last step completes.
module calc_div_iter #(
  parameter int DVD_W = 22,
  parameter int DVS_W = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             i_abort,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(DVD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

  logic [DVD_W-1:0] r_quo;
  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [DVS_W:0]   w_shift;
  logic             w_ge;
  logic [DVS_W-1:0] w_rem_nxt;
  logic [DVD_W-1:0] w_quo_nxt;

  // Remainder stays below the divisor, so it fits DVS_W bits between steps.
  assign w_shift   = {r_rem, r_quo[DVD_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? DVS_W'(w_shift - {1'b0, r_dvs}) : w_shift[DVS_W-1:0];
  assign w_quo_nxt = {r_quo[DVD_W-2:0], w_ge};

  assign o_done     = r_run && (r_cnt == CNT_LAST);
  assign o_quotient = w_quo_nxt;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_abort) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      if (o_done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator arithmetic sequencer: valid/ready request in, saturated Q1.9.6
// response out. ADD/SUB/MUL finish in EXEC; DIV runs the iterative divider.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W   = Q_W,
  parameter int FRAC_W   = Q_FRAC,
  parameter int DIV_BITS = DATA_W + FRAC_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              abort,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf,
  output logic              rsp_dz,
  output logic              rsp_badop,
  output logic              busy
);

  localparam logic [DIV_BITS-1:0] POS_LIM = {{(DIV_BITS-DATA_W){1'b0}}, Q_MAX};
  localparam logic [DIV_BITS-1:0] NEG_LIM = {{(DIV_BITS-DATA_W){1'b0}}, Q_MIN};

  state_t            r_state;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  rsp_t              r_rsp;
  logic              r_valid;

  logic [DATA_W:0]     w_sum;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_prod_sh;
  logic [DATA_W:0]     w_mul_hi;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_neg;
  logic                w_div_start;
  logic                w_div_done;
  logic [DIV_BITS-1:0] w_quo;
  rsp_t                w_exec;
  rsp_t                w_div;

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign rsp_valid  = r_valid;
  assign rsp_result = r_rsp.result;
  assign rsp_ovf    = r_rsp.ovf;
  assign rsp_dz     = r_rsp.dz;
  assign rsp_badop  = r_rsp.badop;

  // One extra sign bit makes ADD/SUB overflow a simple top-two-bit mismatch.
  assign w_sum = (r_op == OP_SUB) ? ({r_a[DATA_W-1], r_a} - {r_b[DATA_W-1], r_b})
                                  : ({r_a[DATA_W-1], r_a} + {r_b[DATA_W-1], r_b});

  assign w_prod    = $signed({{DATA_W{r_a[DATA_W-1]}}, r_a}) *
                     $signed({{DATA_W{r_b[DATA_W-1]}}, r_b});
  assign w_prod_sh = w_prod >>> FRAC_W;
  assign w_mul_hi  = w_prod_sh[2*DATA_W-1:DATA_W-1];

  // 0x8000 negates to itself, which reads correctly as the unsigned 32768.
  assign w_mag_a     = r_a[DATA_W-1] ? (~r_a + 1'b1) : r_a;
  assign w_mag_b     = r_b[DATA_W-1] ? (~r_b + 1'b1) : r_b;
  assign w_neg       = r_a[DATA_W-1] ^ r_b[DATA_W-1];
  assign w_div_start = (r_state == ST_EXEC) && (r_op == OP_DIV) && (r_b != '0);

  calc_div_iter #(
    .DVD_W (DIV_BITS),
    .DVS_W (DATA_W)
  ) u_div (
    .clk        (clk),
    .clear_n    (clear_n),
    .i_abort    (abort),
    .i_start    (w_div_start),
    .i_dividend ({w_mag_a, {FRAC_W{1'b0}}}),
    .i_divisor  (w_mag_b),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_comb begin
    w_exec = '0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
          w_exec.ovf    = 1'b1;
          w_exec.result = w_sum[DATA_W] ? Q_MIN : Q_MAX;
        end else begin
          w_exec.result = w_sum[DATA_W-1:0];
        end
      end
      OP_MUL: begin
        if ((&w_mul_hi) || !(|w_mul_hi)) begin
          w_exec.result = w_prod_sh[DATA_W-1:0];
        end else begin
          w_exec.ovf    = 1'b1;
          w_exec.result = w_prod_sh[2*DATA_W-1] ? Q_MIN : Q_MAX;
        end
      end
      // EXEC only completes a DIV itself when the divisor is zero.
      OP_DIV:  w_exec.dz    = 1'b1;
      default: w_exec.badop = 1'b1;
    endcase
  end

  always_comb begin
    w_div = '0;
    if (w_neg) begin
      if (w_quo > NEG_LIM) begin
        w_div.ovf    = 1'b1;
        w_div.result = Q_MIN;
      end else begin
        w_div.result = ~w_quo[DATA_W-1:0] + 1'b1;
      end
    end else begin
      if (w_quo > POS_LIM) begin
        w_div.ovf    = 1'b1;
        w_div.result = Q_MAX;
      end else begin
        w_div.result = w_quo[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rsp   <= '0;
      r_valid <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_div_start) begin
            r_state <= ST_DIV_RUN;
          end else begin
            r_rsp   <= w_exec;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_DIV_RUN: begin
          if (w_div_done) begin
            r_rsp   <= w_div;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed latency/saturation/abort/
// reset cases, then randomized traffic against an integer arithmetic model.
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        abort = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_ovf, rsp_dz, rsp_badop, busy;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        dz;
    logic        bad;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_bp = 1'b0;

  calc_op_sequencer dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .abort      (abort),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .rsp_dz     (rsp_dz),
    .rsp_badop  (rsp_badop),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Real-number semantics on integers: Q values are scaled by 64.
  function automatic exp_t model(int op, logic [15:0] a, logic [15:0] b);
    exp_t e;
    int sa = $signed(a);
    int sb = $signed(b);
    int r  = 0;
    int ma, mb;
    e.res = 16'h0; e.ovf = 1'b0; e.dz = 1'b0; e.bad = 1'b0;
    case (op)
      1: r = sa + sb;
      2: r = sa - sb;
      3: r = (sa * sb) >>> 6;
      4: begin
        if (sb == 0) begin
          e.dz = 1'b1;
          return e;
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        r  = (ma * 64) / mb;
        if ((sa < 0) != (sb < 0)) r = -r;
      end
      default: begin
        e.bad = 1'b1;
        return e;
      end
    endcase
    if (r > 32767) begin
      e.res = 16'h7FFF; e.ovf = 1'b1;
    end else if (r < -32768) begin
      e.res = 16'h8000; e.ovf = 1'b1;
    end else begin
      e.res = r[15:0];
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic fail_now(string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor: compares each handshaken response with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (clear_n && !abort && rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sbq.pop_front();
          chk("rsp_result", {16'h0, rsp_result}, {16'h0, e.res});
          chk("rsp_flags", {29'h0, rsp_ovf, rsp_dz, rsp_badop}, {29'h0, e.ovf, e.dz, e.bad});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_bp) rsp_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered at a negedge; returns at a negedge after the accept edge.
  task automatic send(int op, logic [15:0] a, logic [15:0] b);
    int t = 0;
    req_op = op[2:0]; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      fail_now("send_ready");
      req_valid = 1'b0;
      return;
    end
    sbq.push_back(model(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("drain");
  endtask

  // Latency in cycles from the request cycle to the first rsp_valid cycle.
  task automatic lat_op(int op, logic [15:0] a, logic [15:0] b, int want, string nm);
    int lat = 1;
    bit idle_seen = 1'b0;
    rsp_ready = 1'b0;
    chk({nm, "_ready"}, {31'h0, req_ready}, 32'd1);
    send(op, a, b);
    while (!rsp_valid && lat < 60) begin
      if (!busy) idle_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, want);
    chk({nm, "_busy"}, {31'h0, idle_seen}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [15:0] rnd_q();
    int s;
    case ($urandom_range(5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: begin
        s = int'($urandom_range(2047)) - 1024;
        return s[15:0];
      end
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] hold;
    int k, op;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_result", {16'h0, rsp_result}, 32'd0);
    chk("rst_flags", {29'h0, rsp_ovf, rsp_dz, rsp_badop}, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    lat_op(1, 16'h00A0, 16'h0050, 2,  "add");
    chk("add_value", {16'h0, rsp_result}, 32'h00F0);
    lat_op(3, 16'h00A0, 16'hFFA0, 2,  "mul");
    lat_op(3, 16'h4000, 16'h0100, 2,  "mul_sat");
    lat_op(4, 16'h01E0, 16'h00A0, 24, "div");
    chk("div_value", {16'h0, rsp_result}, 32'h00C0);
    lat_op(4, 16'hFF10, 16'h00A0, 24, "div_neg");
    lat_op(4, 16'h0123, 16'h0000, 2,  "div_zero");
    lat_op(4, 16'h8000, 16'h0040, 24, "div_min");
    lat_op(4, 16'h8000, 16'hFFC0, 24, "div_sat");
    lat_op(1, 16'h7000, 16'h2000, 2,  "add_sat");
    lat_op(2, 16'h8000, 16'h0040, 2,  "sub_sat");
    lat_op(7, 16'h1234, 16'h5678, 2,  "badop");

    // Backpressure then back-to-back request.
    send(2, 16'h0300, 16'h0123);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    hold = rsp_result;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_stable", {16'h0, rsp_result}, {16'h0, hold});
      chk("bp_ready", {31'h0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_op = 3'd1; req_a = 16'h0041; req_b = 16'hFF00; req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready", {31'h0, req_ready}, 32'd1);
    sbq.push_back(model(1, 16'h0041, 16'hFF00));
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 32'd1);
    drain();
    rsp_ready = 1'b0;

    // Abort at divider iteration 10.
    send(4, 16'h01E0, 16'h00A0);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_norsp", {31'h0, seen}, 32'd0);
    lat_op(1, 16'h0100, 16'h0100, 2, "post_abort");

    // Abort beats a simultaneous request.
    abort = 1'b1; req_op = 3'd1; req_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    chk("abort_req_busy", {31'h0, busy}, 32'd0);

    // Asynchronous clear mid-DIV; the previous result was nonzero.
    send(4, 16'h0500, 16'h0070);
    repeat (5) @(negedge clk);
    #1 clear_n = 1'b0;
    #1;
    chk("clr_valid", {31'h0, rsp_valid}, 32'd0);
    chk("clr_busy", {31'h0, busy}, 32'd0);
    chk("clr_result", {16'h0, rsp_result}, 32'd0);
    chk("clr_flags", {29'h0, rsp_ovf, rsp_dz, rsp_badop}, 32'd0);
    sbq.delete();
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with random consumer backpressure.
    rnd_bp = 1'b1;
    repeat (300) begin
      k = $urandom_range(9);
      if (k < 2) op = 1;
      else if (k < 4) op = 2;
      else if (k < 6) op = 3;
      else if (k < 8) op = 4;
      else if (k == 8) op = ($urandom_range(1) != 0) ? 0 : int'($urandom_range(7, 5));
      else op = 4;
      send(op, rnd_q(), (k == 9) ? 16'h0000 : rnd_q());
      repeat ($urandom_range(2)) @(negedge clk);
    end
    rnd_bp = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
